// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for the shared tri-state inter-CiM bus.
//               Grants one owner at a time, with a one-cycle turnaround between
//               owners. The master may take priority via master_priority.
//               Optional macro BUS_ARB_TIMEOUT_EN adds a forced-release
//               watchdog with a sticky timeout_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_REQ        = 65,
    parameter int MASTER_IDX     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    input  logic                       master_priority,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       grant_valid,
    output logic                       bus_busy,
    output logic                       timeout_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_rr_ptr;
    logic                r_grant_valid;
    logic                r_bus_busy;

    logic [ID_W-1:0]     w_rr_winner;
    logic                w_rr_found;
    logic [ID_W-1:0]     w_winner;
    logic [NUM_REQ-1:0]  w_winner_onehot;
    logic [ID_W-1:0]     w_next_ptr;
    logic                w_timeout;
    logic                w_release;
    int                  w_k;

    // Round-robin scan: first requester at or above rr_ptr, wrapping at NUM_REQ-1
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = '0;
        w_k         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = int'(r_rr_ptr) + i;
            if (w_k >= NUM_REQ) begin
                w_k = w_k - NUM_REQ;
            end
            if (!w_rr_found && req[w_k[ID_W-1:0]]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = w_k[ID_W-1:0];
            end
        end
    end

    // Master override beats the round-robin choice when it is requesting
    assign w_winner        = (master_priority && req[MASTER_IDX]) ? ID_W'(MASTER_IDX) : w_rr_winner;
    assign w_winner_onehot = NUM_REQ'(1) << w_winner;

    // The releasing owner becomes lowest priority next round
    assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    // Owner leaves on its done pulse, on dropping its request, or on watchdog expiry
    assign w_release = done[r_grant_id] | ~req[r_grant_id] | w_timeout;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] r_own_cnt;
    logic [7:0] w_own_cnt_next;
    logic       r_timeout_err;

    // Value own_cnt reaches once the current OWNED cycle is counted; the owner
    // therefore holds the bus for exactly TIMEOUT_CYCLES cycles at most
    assign w_own_cnt_next = r_own_cnt + 8'd1;
    assign w_timeout      = (r_state == ST_OWNED) && (w_own_cnt_next == 8'(TIMEOUT_CYCLES));

    // Ownership watchdog: cleared on entry to OWNED, error flag sticky until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_own_cnt     <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_OWNED) begin
                r_own_cnt <= w_own_cnt_next;
            end else begin
                r_own_cnt <= 8'd0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Ownership FSM: IDLE arbitrates, OWNED holds, TURNAROUND keeps the bus quiet one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_grant_valid <= 1'b0;
            r_bus_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant       <= w_winner_onehot;
                        r_grant_id    <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_bus_busy    <= 1'b1;
                        r_state       <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (w_release) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_rr_ptr      <= w_next_ptr;
                        r_state       <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    r_bus_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_bus_busy    <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign bus_busy    = r_bus_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter. Stimulus queues the
//               expected grant sequence; a negedge monitor pops and checks
//               each new grant, hold length, spacing and bus_busy/reset state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int NUM_REQ    = 65;
    localparam int MASTER_IDX = 64;
    localparam int ID_W       = 7;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  done;
    logic                master_priority;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                grant_valid;
    logic                bus_busy;
    logic                timeout_err;

    bus_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .MASTER_IDX     (MASTER_IDX),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .done            (done),
        .master_priority (master_priority),
        .grant           (grant),
        .grant_id        (grant_id),
        .grant_valid     (grant_valid),
        .bus_busy        (bus_busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int len;   // expected grant length in cycles, 0 = not checked
        int gap;   // expected cycles from previous last-owned cycle, 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    logic exp_terr = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   cyc        = 0;
    int   start_cyc  = 0;
    int   last_owned = -100;
    int   cur_len    = 0;
    logic prev_valid = 1'b0;
    logic last_rst   = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!last_rst) begin
            chk("rst_grant",       128'(grant),       128'(0));
            chk("rst_grant_id",    128'(grant_id),    128'(0));
            chk("rst_grant_valid", 128'(grant_valid), 128'(0));
            chk("rst_bus_busy",    128'(bus_busy),    128'(0));
            chk("rst_timeout_err", 128'(timeout_err), 128'(0));
            exp_terr = 1'b0;
        end else begin
            chk("valid_vs_grant", 128'(grant_valid), 128'(|grant));
            chk("grant_onehot0",  128'($onehot0(grant)), 128'(1));
            // busy while owned and for the single turnaround cycle after release
            chk("bus_busy", 128'(bus_busy), 128'(grant_valid | (prev_valid & ~grant_valid)));
            chk("timeout_err", 128'(timeout_err), 128'(exp_terr));
            if (grant_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got id %0d expected none at %0t", grant_id, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", 128'(grant_id), 128'(e.id));
                    chk("grant_vec", 128'(grant), 128'(1) << e.id);
                    if (e.gap != 0) begin
                        chk("grant_gap", 128'(cyc - last_owned), 128'(e.gap));
                    end
                    start_cyc = cyc;
                    cur_len   = e.len;
                end
            end
            if (!grant_valid && prev_valid) begin
                if (cur_len != 0) begin
                    chk("hold_len", 128'(cyc - start_cyc), 128'(cur_len));
                end
                last_owned = cyc - 1;
            end
        end
        if (!last_rst) begin
            cur_len = 0;
        end
        prev_valid = grant_valid;
        last_rst   = rst_n;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int id, input int len, input int gap);
        exp_q.push_back('{id: id, len: len, gap: gap});
    endtask

    task automatic wait_grant(input int id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (grant_valid && grant_id == ID_W'(id)) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_grant: no grant to %0d within 50 cycles, grant_id %0d", id, grant_id);
        end
    endtask

    // Owner behaviour: hold n cycles, pulse done on the last one, optionally drop req
    task automatic serve(input int id, input int n, input bit drop);
        bit ok;
        wait_grant(id, ok);
        if (ok) begin
            tick(n - 1);
            done[id] = 1'b1;
            tick(1);
            done[id] = 1'b0;
        end
        if (drop) begin
            req[id] = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        rst_n           = 1'b0;
        req             = '0;
        done            = '0;
        master_priority = 1'b0;
        tick(2);
        rst_n = 1'b1;

        // Idle with no requests: monitor sees no grant and no busy
        tick(10);

        // Three held requesters rotate 2 -> 5 -> 63 -> 2 with 3-cycle spacing
        expect_grant(2, 2, 0);
        expect_grant(5, 2, 3);
        expect_grant(63, 2, 3);
        expect_grant(2, 2, 3);
        req[2]  = 1'b1;
        req[5]  = 1'b1;
        req[63] = 1'b1;
        serve(2, 2, 1'b0);
        serve(5, 2, 1'b0);
        serve(63, 2, 1'b0);
        serve(2, 2, 1'b0);
        req = '0;
        tick(4);

        // Single requester: grant cycles 1-5, turnaround at 6, idle at 7
        expect_grant(3, 5, 0);
        req[3] = 1'b1;
        serve(3, 5, 1'b1);
        tick(4);

        // Master priority wins over CiM 10, then CiM 10
        master_priority = 1'b1;
        expect_grant(64, 2, 0);
        expect_grant(10, 2, 3);
        req[10] = 1'b1;
        req[64] = 1'b1;
        serve(64, 2, 1'b1);
        serve(10, 2, 1'b1);
        tick(4);

        // Master grant wraps rr_ptr to 0; then without priority CiM 10 goes first
        expect_grant(64, 2, 0);
        req[64] = 1'b1;
        serve(64, 2, 1'b1);
        tick(4);
        master_priority = 1'b0;
        expect_grant(10, 2, 0);
        expect_grant(64, 2, 3);
        req[10] = 1'b1;
        req[64] = 1'b1;
        serve(10, 2, 1'b1);
        serve(64, 2, 1'b1);
        tick(4);

        // Move rr_ptr to 5, then reset mid-ownership of 7: pointer must return to 0
        expect_grant(4, 2, 0);
        req[4] = 1'b1;
        serve(4, 2, 1'b1);
        tick(4);
        expect_grant(7, 0, 0);
        req[7] = 1'b1;
        wait_grant(7, ok);
        tick(2);
        rst_n  = 1'b0;
        req[7] = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        expect_grant(1, 2, 0);
        expect_grant(7, 2, 3);
        req[1] = 1'b1;
        req[7] = 1'b1;
        serve(1, 2, 1'b1);
        serve(7, 2, 1'b1);
        tick(4);

`ifdef BUS_ARB_TIMEOUT_EN
        // Owner never finishes: forced release after 255 owned cycles, sticky error
        expect_grant(4, 255, 0);
        req[4] = 1'b1;
        wait_grant(4, ok);
        tick(255);
        exp_terr = 1'b1;
        req[4]   = 1'b0;
        tick(6);
`else
        // Owner never finishes: grant held for 1000 cycles with no forced release
        expect_grant(4, 1000, 0);
        req[4] = 1'b1;
        serve(4, 1000, 1'b1);
        tick(4);
`endif

        // Final reset clears every output including the sticky error
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_grants: got %0d outstanding expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
